// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the LCD serial link: word size, receiver state
// encoding and D/C bit meaning (also used by the LCD init transmitter).
package lcd_spi_pkg;

    localparam int WORD_BITS_DEF = 9;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_e;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/lcd_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, plus one extra flop
// so the synchronized level can be compared against its previous value.
module lcd_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = SYNC_STAGES'({sync_q, din});
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign lvl  = sync_q[SYNC_STAGES-1];
    assign rise = lvl & ~prev_q;
    assign fall = ~lvl & prev_q;

endmodule

// File: rtl/lcd_spi_rx.sv
// Receiver for the 3-wire LCD serial bus: D/C bit plus 8 data bits per word,
// oversampled in the sys_clk domain and handed out over a valid/ready port.
module lcd_spi_rx
    import lcd_spi_pkg::*;
#(
    parameter int WORD_BITS   = WORD_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        CS,
    input  logic        SCL,
    input  logic        SDA,
    input  logic        rx_ready,
    output logic        rx_valid,
    output logic        rx_dc,
    output logic [7:0]  rx_data,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun,
    output logic [15:0] word_cnt
);

    localparam logic [3:0] LAST_BIT = 4'(WORD_BITS - 1);

    logic cs_lvl, cs_rise, cs_fall;
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    lcd_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(sys_clk), .rst_n(sys_rst_n), .din(CS),
        .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    lcd_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_scl (
        .clk(sys_clk), .rst_n(sys_rst_n), .din(SCL),
        .lvl(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    lcd_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sda (
        .clk(sys_clk), .rst_n(sys_rst_n), .din(SDA),
        .lvl(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    logic unused_edges;
    assign unused_edges = &{1'b0, cs_lvl, scl_lvl, scl_fall, sda_rise, sda_fall};

    rx_state_e            state_q, state_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic                 done_q, done_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_dc_q, rx_dc_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic [15:0]          word_cnt_q, word_cnt_d;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        done_d      = 1'b0;
        rx_valid_d  = rx_valid_q;
        rx_dc_d     = rx_dc_q;
        rx_data_d   = rx_data_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;
        word_cnt_d  = word_cnt_q;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        // A word completed last cycle: deliver it unless the old one is still unconsumed.
        if (done_q) begin
            if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                rx_valid_d = 1'b1;
                rx_dc_d    = shreg_q[WORD_BITS-1];
                rx_data_d  = shreg_q[7:0];
                word_cnt_d = word_cnt_q + 16'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 4'd0;
                end
            end
            ST_SHIFT: begin
                // CS release wins over a simultaneous SCL edge.
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (bit_cnt_q != 4'd0);
                    bit_cnt_d   = 4'd0;
                    shreg_d     = '0;
                end else if (scl_rise) begin
                    shreg_d = {shreg_q[WORD_BITS-2:0], sda_lvl};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = 4'd0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shreg_q     <= '0;
            done_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_dc_q     <= 1'b0;
            rx_data_q   <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            word_cnt_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            done_q      <= done_d;
            rx_valid_q  <= rx_valid_d;
            rx_dc_q     <= rx_dc_d;
            rx_data_q   <= rx_data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign rx_valid  = rx_valid_q;
    assign rx_dc     = rx_dc_q;
    assign rx_data   = rx_data_q;
    assign busy      = (state_q == ST_SHIFT);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Scoreboard bench for lcd_spi_rx: expected words are queued as they are
// sent and popped by a monitor whenever the DUT hands a word downstream.
module tb_lcd_spi_rx;

    localparam int HALF = 5;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        CS = 1'b1;
    logic        SCL = 1'b0;
    logic        SDA = 1'b0;
    logic        rx_ready = 1'b1;
    logic        rx_valid;
    logic        rx_dc;
    logic [7:0]  rx_data;
    logic        busy;
    logic        frame_err;
    logic        overrun;
    logic [15:0] word_cnt;

    lcd_spi_rx #(.WORD_BITS(9), .SYNC_STAGES(2)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .CS(CS), .SCL(SCL), .SDA(SDA), .rx_ready(rx_ready),
        .rx_valid(rx_valid), .rx_dc(rx_dc), .rx_data(rx_data),
        .busy(busy), .frame_err(frame_err), .overrun(overrun), .word_cnt(word_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    logic [8:0]  sb_q[$];
    int          delivered = 0;
    int          fe_pulses = 0;
    logic        fe_prev = 1'b0;
    logic [15:0] exp_cnt = 16'd0;

    // Monitor: pops the scoreboard on every handshake and watches frame_err width.
    always @(negedge sys_clk) begin
        if (rx_valid && rx_ready) begin
            logic [8:0] exp_w;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word got dc=%0b data=%02h, required none", rx_dc, rx_data);
            end else begin
                exp_w = sb_q.pop_front();
                if ({rx_dc, rx_data} !== exp_w) begin
                    errors++;
                    $display("FAIL word got dc=%0b data=%02h, required dc=%0b data=%02h",
                             rx_dc, rx_data, exp_w[8], exp_w[7:0]);
                end
            end
            delivered++;
        end
        if (frame_err && fe_prev) begin
            checks++;
            errors++;
            $display("FAIL frame_err_width got high two cycles, required one-cycle pulse");
        end
        if (frame_err && !fe_prev) fe_pulses++;
        fe_prev = frame_err;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic cs_low();
        CS = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic cs_high();
        wait_clks(HALF);
        CS = 1'b1;
        wait_clks(10);
    endtask

    task automatic send_bits(input logic [8:0] w, input int n);
        for (int i = 8; i > 8 - n; i--) begin
            SDA = w[i];
            wait_clks(HALF);
            SCL = 1'b1;
            wait_clks(HALF);
            SCL = 1'b0;
        end
    endtask

    task automatic send_word(input logic [8:0] w, input bit expect_it);
        if (expect_it) begin
            sb_q.push_back(w);
            exp_cnt = exp_cnt + 16'd1;
        end
        send_bits(w, 9);
    endtask

    task automatic test_reset();
        wait_clks(3);
        checks++;
        if ({rx_valid, rx_dc, rx_data, busy, frame_err, overrun, word_cnt} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b dc=%0b d=%02h busy=%0b fe=%0b ovr=%0b cnt=%0d, required all 0",
                     rx_valid, rx_dc, rx_data, busy, frame_err, overrun, word_cnt);
        end
        sys_rst_n = 1'b1;
        wait_clks(5);
        checks++;
        if (busy !== 1'b0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%0b valid=%0b, required 0 0", busy, rx_valid);
        end
    endtask

    task automatic test_single();
        int d0 = delivered;
        cs_low();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_shift got %0b, required 1", busy);
        end
        send_word({1'b0, 8'h11}, 1'b1);
        cs_high();
        checks++;
        if (delivered - d0 !== 1 || word_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL single_word got delivered=%0d cnt=%0d, required 1 %0d", delivered - d0, word_cnt, exp_cnt);
        end
        checks++;
        if (busy !== 1'b0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got busy=%0b valid=%0b, required 0 0", busy, rx_valid);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = delivered;
        int f0 = fe_pulses;
        cs_low();
        send_word({1'b1, 8'h2C}, 1'b1);
        send_word({1'b1, 8'hFF}, 1'b1);
        cs_high();
        checks++;
        if (delivered - d0 !== 2 || sb_q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_count got delivered=%0d pending=%0d, required 2 0", delivered - d0, sb_q.size());
        end
        checks++;
        if (fe_pulses !== f0 || word_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL b2b_status got fe=%0d cnt=%0d, required %0d %0d", fe_pulses, word_cnt, f0, exp_cnt);
        end
    endtask

    task automatic test_frame_err();
        int d0 = delivered;
        int f0 = fe_pulses;
        cs_low();
        send_bits({1'b1, 8'hA5}, 4);
        cs_high();
        checks++;
        if (fe_pulses - f0 !== 1 || delivered !== d0) begin
            errors++;
            $display("FAIL partial_word got fe=%0d delivered=%0d, required 1 0", fe_pulses - f0, delivered - d0);
        end
        cs_low();
        send_word({1'b0, 8'h29}, 1'b1);
        cs_high();
        checks++;
        if (delivered - d0 !== 1 || fe_pulses - f0 !== 1 || word_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL after_frame_err got delivered=%0d fe=%0d cnt=%0d, required 1 1 %0d",
                     delivered - d0, fe_pulses - f0, word_cnt, exp_cnt);
        end
    endtask

    task automatic test_cs_priority();
        int d0 = delivered;
        int f0 = fe_pulses;
        cs_low();
        send_bits({1'b0, 8'h5A}, 8);
        SDA = 1'b0;
        wait_clks(HALF);
        SCL = 1'b1;
        CS  = 1'b1;
        wait_clks(HALF);
        SCL = 1'b0;
        wait_clks(10);
        checks++;
        if (delivered !== d0 || fe_pulses - f0 !== 1 || word_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL cs_priority got delivered=%0d fe=%0d cnt=%0d, required 0 1 %0d",
                     delivered - d0, fe_pulses - f0, word_cnt, exp_cnt);
        end
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_initial got %0b, required 0", overrun);
        end
        cs_low();
        send_word({1'b0, 8'hAA}, 1'b1);
        send_word({1'b0, 8'h55}, 1'b0);
        cs_high();
        checks++;
        if (rx_valid !== 1'b1 || rx_dc !== 1'b0 || rx_data !== 8'hAA) begin
            errors++;
            $display("FAIL overrun_hold got v=%0b dc=%0b d=%02h, required 1 0 aa", rx_valid, rx_dc, rx_data);
        end
        checks++;
        if (overrun !== 1'b1 || word_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL overrun_flag got ovr=%0b cnt=%0d, required 1 %0d", overrun, word_cnt, exp_cnt);
        end
        rx_ready = 1'b1;
        wait_clks(4);
        checks++;
        if (rx_valid !== 1'b0 || sb_q.size() !== 0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_drain got v=%0b pending=%0d ovr=%0b, required 0 0 1", rx_valid, sb_q.size(), overrun);
        end
    endtask

    task automatic test_reset_midword();
        cs_low();
        send_bits({1'b1, 8'hF0}, 5);
        sys_rst_n = 1'b0;
        wait_clks(2);
        checks++;
        if ({rx_valid, rx_dc, rx_data, busy, frame_err, overrun, word_cnt} !== 29'd0) begin
            errors++;
            $display("FAIL midword_reset got v=%0b dc=%0b d=%02h busy=%0b fe=%0b ovr=%0b cnt=%0d, required all 0",
                     rx_valid, rx_dc, rx_data, busy, frame_err, overrun, word_cnt);
        end
        CS = 1'b1;
        wait_clks(2);
        sys_rst_n = 1'b1;
        exp_cnt = 16'd0;
        wait_clks(5);
        cs_low();
        send_word({1'b1, 8'h3C}, 1'b1);
        cs_high();
        checks++;
        if (rx_dc !== 1'b1 || rx_data !== 8'h3C || word_cnt !== 16'd1 || sb_q.size() !== 0) begin
            errors++;
            $display("FAIL after_reset got dc=%0b d=%02h cnt=%0d pending=%0d, required 1 3c 1 0",
                     rx_dc, rx_data, word_cnt, sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_cs_priority();
        test_overrun();
        test_reset_midword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
